// File: rtl/inst_mem_loader.sv
// inst_mem_loader: byte-wide instruction memory with a handshake loader.
// 16-bit words arrive over a valid/ready handshake. Each word is stored
// big-endian as a byte pair: the high byte goes to the even address and the
// low byte to the next address. A combinational fetch port reads back the
// same byte-pair layout from any (possibly odd) byte address.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   load_en      1 = loading mode, 0 = run mode (also restarts after done/full)
//   in_valid     source presents in_inst / in_last
//   in_ready     loader accepts a word this cycle (IDLE only)
//   in_inst      16-bit instruction word
//   in_last      marks the final word of the program
//   wr_addr      byte address of the next high byte to be written (even)
//   inst_count   complete instructions written since the last restart
//   done         program completed by an accepted last word
//   full         memory filled (wr_addr == MEM_BYTES)
//   overflow     sticky: in_valid seen while full and loading
//   rd_addr      fetch byte address
//   rd_inst      {mem[rd_addr], mem[rd_addr+1]}, wrapping at MEM_BYTES
module inst_mem_loader #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_inst,
    input  logic              in_last,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        inst_count,
    output logic              done,
    output logic              full,
    output logic              overflow,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_inst
);

    localparam int unsigned IDX_W    = (MEM_BYTES > 2) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned MAX_INST = MEM_BYTES / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WR_HI,
        S_WR_LO,
        S_DONE,
        S_FULL
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;

    logic [7:0]        mem_q [MEM_BYTES];

    logic [ADDR_W-1:0] next_addr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  rd_idx_nxt;
    logic              unused_rd_hi;

    // Next-state, handshake and bookkeeping
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        last_d    = last_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        full_d    = full_q;
        ovf_d     = ovf_q;
        next_addr = wr_addr_q + ADDR_W'(2);
        // Held low during reset so the reset value of in_ready is observed as 0
        in_ready  = (state_q == S_IDLE) & load_en & ~full_q & ~done_q & ~rst;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    word_d  = in_inst;
                    last_d  = in_last;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_WR_HI;
            S_WR_HI:   state_d = S_WR_LO;
            S_WR_LO: begin
                wr_addr_d = next_addr;
                if (cnt_q < 8'(MAX_INST)) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (next_addr == ADDR_W'(MEM_BYTES)) begin
                    full_d = 1'b1;
                end
                // A last word that also fills memory ends in DONE with both flags set
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (next_addr == ADDR_W'(MEM_BYTES)) begin
                    state_d = S_FULL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE, S_FULL: begin
                if (!load_en) begin
                    state_d   = S_IDLE;
                    wr_addr_d = '0;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    full_d    = 1'b0;
                    ovf_d     = 1'b0;
                end else if (in_valid && full_q) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            last_q    <= 1'b0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            last_q    <= last_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    // Byte storage; never reset, and a reset edge abandons the pending write
    assign wr_idx = wr_addr_q[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_WR_HI) begin
                mem_q[wr_idx] <= word_q[15:8];
            end
            if (state_q == S_WR_LO) begin
                mem_q[wr_idx + IDX_W'(1)] <= word_q[7:0];
            end
        end
    end

    // Fetch port: second byte wraps to address 0 past the top of memory
    assign rd_idx       = rd_addr[IDX_W-1:0];
    assign rd_idx_nxt   = (rd_idx == IDX_W'(MEM_BYTES - 1)) ? '0 : rd_idx + IDX_W'(1);
    assign rd_inst      = {mem_q[rd_idx], mem_q[rd_idx_nxt]};
    assign unused_rd_hi = ^rd_addr[ADDR_W-1:IDX_W];

    assign wr_addr    = wr_addr_q;
    assign inst_count = cnt_q;
    assign done       = done_q;
    assign full       = full_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed testbench for inst_mem_loader: a per-cycle vector table for the
// basic load/restart flow, then hand-written fill, stall, reset and
// simultaneity sequences checked against a byte-array memory model.
module tb_inst_mem_loader;

    localparam int unsigned MEM_BYTES = 128;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned N_VEC     = 20;

    logic              clk;
    logic              rst;
    logic              load_en;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_inst;
    logic              in_last;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        inst_count;
    logic              done;
    logic              full;
    logic              overflow;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_inst;

    int checks;
    int errors;

    logic [7:0] exp_mem [MEM_BYTES];
    int         exp_addr;

    typedef struct {
        logic        rst;
        logic        le;
        logic        valid;
        logic [15:0] inst;
        logic        last;
        logic [15:0] rd;
        logic        chk;
        logic        e_ready;
        logic [15:0] e_addr;
        logic [7:0]  e_cnt;
        logic        e_done;
        logic        e_full;
        logic        e_ovf;
        logic        chk_rd;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vecs [N_VEC];

    inst_mem_loader #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_last   (in_last),
        .wr_addr   (wr_addr),
        .inst_count(inst_count),
        .done      (done),
        .full      (full),
        .overflow  (overflow),
        .rd_addr   (rd_addr),
        .rd_inst   (rd_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic rdy, input int addr,
                              input int cnt, input logic dn, input logic fl, input logic ov);
        chk({name, "_ready"}, 32'(in_ready), 32'(rdy));
        chk({name, "_wr_addr"}, 32'(wr_addr), 32'(addr));
        chk({name, "_count"}, 32'(inst_count), 32'(cnt));
        chk({name, "_done"}, 32'(done), 32'(dn));
        chk({name, "_full"}, 32'(full), 32'(fl));
        chk({name, "_overflow"}, 32'(overflow), 32'(ov));
    endtask

    task automatic rd_chk(input string name, input int addr);
        int a0;
        int a1;
        a0 = addr % MEM_BYTES;
        a1 = (a0 + 1) % MEM_BYTES;
        rd_addr = 16'(addr);
        #1;
        chk(name, 32'(rd_inst), 32'({exp_mem[a0], exp_mem[a1]}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        load_en  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        exp_addr = 0;
    endtask

    // Offer one word, wait (bounded) for acceptance, return after its WR_LO edge
    task automatic send_word(input logic [15:0] w, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = w;
        in_last  = last;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        exp_mem[exp_addr]     = w[15:8];
        exp_mem[exp_addr + 1] = w[7:0];
        exp_addr += 2;
    endtask

    function automatic logic [15:0] fill_word(input int i);
        return {8'(i * 3 + 1), 8'(240 - i)};
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        exp_addr = 0;
        rst      = 1'b1;
        load_en  = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        in_last  = 1'b0;
        rd_addr  = '0;

        // rst le vl inst last rd | chk rdy addr cnt dn fl ov | chkrd rd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'd0, 1'b1, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'hABCD, 1'b1, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'hABCD, 1'b1, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'hABCD, 1'b1, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'hABCD, 1'b1, 16'd0, 1'b1, 1'b1, 16'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd1, 1'b1, 1'b0, 16'd2, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h34AB};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd2, 1'b1, 1'b0, 16'd4, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'hABCD};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 16'd1, 1'b1, 1'b0, 16'd4, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h34AB};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd4, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd4, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 16'd0, 1'b1, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5534};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd2, 1'b1, 1'b0, 16'd2, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hABCD};

        // Basic load of 0x1234/0xABCD, then restart with 0x5555
        for (int i = 0; i < int'(N_VEC); i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            load_en  = vecs[i].le;
            in_valid = vecs[i].valid;
            in_inst  = vecs[i].inst;
            in_last  = vecs[i].last;
            rd_addr  = vecs[i].rd;
            #1;
            if (vecs[i].chk) begin
                chk_status($sformatf("vec%0d", i), vecs[i].e_ready, int'(vecs[i].e_addr),
                           int'(vecs[i].e_cnt), vecs[i].e_done, vecs[i].e_full, vecs[i].e_ovf);
            end
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d_rd_inst", i), 32'(rd_inst), 32'(vecs[i].e_rd));
            end
        end

        // Fill the whole memory, then poke it while full
        do_reset();
        load_en = 1'b1;
        for (int i = 0; i < int'(MEM_BYTES / 2); i++) begin
            send_word(fill_word(i), 1'b0);
        end
        #1;
        chk_status("fill", 1'b0, int'(MEM_BYTES), int'(MEM_BYTES / 2), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = 16'hDEAD;
        #1;
        chk("ovf_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk_status("ovf", 1'b0, int'(MEM_BYTES), int'(MEM_BYTES / 2), 1'b0, 1'b1, 1'b1);
        for (int a = 0; a < int'(MEM_BYTES); a += 2) begin
            rd_chk($sformatf("fill_rd%0d", a), a);
        end
        rd_chk("fill_rd_odd5", 5);
        rd_chk("fill_rd_top_wrap", int'(MEM_BYTES) - 1);
        rd_chk("fill_rd_alias", int'(MEM_BYTES) + 2);

        // Source gaps and load_en dropped while the word is in WR_HI
        do_reset();
        load_en = 1'b1;
        send_word(16'h1111, 1'b0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("gap_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = 16'h2222;
        in_last  = 1'b0;
        #1;
        chk("stall_accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        load_en = 1'b0;
        #1;
        chk("stall_whi_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = 16'h9999;
        #1;
        chk("stall_wlo_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        exp_mem[2] = 8'h22;
        exp_mem[3] = 8'h22;
        exp_addr   = 4;
        chk_status("stall_done_word", 1'b0, 4, 2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_status("stall_hold", 1'b0, 4, 2, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        load_en  = 1'b1;
        send_word(16'h3333, 1'b1);
        #1;
        chk_status("resume", 1'b0, 6, 3, 1'b1, 1'b0, 1'b0);
        rd_chk("resume_rd0", 0);
        rd_chk("resume_rd2", 2);
        rd_chk("resume_rd4", 4);

        // Reset lands on the WR_LO edge of 0xBEEF at address 6
        do_reset();
        load_en = 1'b1;
        send_word(16'hA0A1, 1'b0);
        send_word(16'hA2A3, 1'b0);
        send_word(16'hA4A5, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = 16'hBEEF;
        #1;
        chk("beef_accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_status("mid_rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        load_en    = 1'b0;
        exp_mem[6] = 8'hBE;
        exp_addr   = 0;
        rd_chk("mid_rst_rd6", 6);
        rd_chk("mid_rst_rd4", 4);

        // Last word also fills memory
        do_reset();
        load_en = 1'b1;
        for (int i = 0; i < int'(MEM_BYTES / 2) - 1; i++) begin
            send_word(fill_word(i) ^ 16'h0F0F, 1'b0);
        end
        send_word(16'hC0DE, 1'b1);
        #1;
        chk_status("simul", 1'b0, int'(MEM_BYTES), int'(MEM_BYTES / 2), 1'b1, 1'b1, 1'b0);
        rd_chk("simul_rd_top", int'(MEM_BYTES) - 2);
        rd_chk("simul_rd_wrap", int'(MEM_BYTES) - 1);
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        #1;
        chk_status("simul_clear", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound in case a sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
